// File: rtl/pit8254_pkg.sv
// Shared definitions for the 8254 counter bus front end.
//   rw_t        : read/write byte-mode encoding held in control_word[5:4]
//   CTRL_ADDR   : port address of the control register
//   READBACK_SC : select-counter code that marks a read-back command
//   status_t    : layout of the status byte returned after a status latch
package pit8254_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    RW_LATCH   = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_t;

  localparam logic [1:0] CTRL_ADDR   = 2'b11;
  localparam logic [1:0] READBACK_SC = 2'b11;

  typedef struct packed {
    logic       out;
    logic       null_count;
    logic [5:0] ctrl;
  } status_t;

  // Pick the high or low byte of a 16-bit count.
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [COUNT_W-1:0] v, input logic hi);
    return hi ? v[COUNT_W-1:BYTE_W] : v[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/counter_bus_interface.sv
// CPU-side read/write front end for one 8254 counter.
// Decodes bus writes into control words, count-register bytes, counter-latch
// and read-back commands; serves status / latched / live count bytes on reads.
// Ports:
//   CLK, RESET                : clock, asynchronous active-high reset
//   CS_n, RD_n, WR_n, A, D_in : CPU bus (strobes synchronous to CLK)
//   current_count, OUT,
//   null_count                : live counter state for reads and status
//   D_out, D_oe               : read data and its enable (combinational)
//   control_word              : stored control word
//   initial_count             : assembled count register
//   CRL_enable, CRM_enable,
//   count_written             : one-cycle write pulses
//   write_pending             : between LSB and MSB writes in LSB/MSB mode
module counter_bus_interface
  import pit8254_pkg::*;
#(
  parameter int unsigned COUNTER_ID = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [1:0]  A,
  input  logic [7:0]  D_in,
  input  logic [15:0] current_count,
  input  logic        OUT,
  input  logic        null_count,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic [7:0]  control_word,
  output logic [15:0] initial_count,
  output logic        CRL_enable,
  output logic        CRM_enable,
  output logic        count_written,
  output logic        write_pending
);

  localparam logic [1:0]  ID     = 2'(COUNTER_ID);
  localparam int unsigned RB_BIT = COUNTER_ID + 1;

  logic        wr_q, rd_q;
  logic        read_toggle;
  logic        ol_latched, status_latched;
  logic [15:0] ol;
  status_t     status;
  rw_t         rw;

  logic write_event, read_event;
  logic ctrl_hit, readback_hit, data_hit;
  logic ctrl_store, latch_count, latch_status;
  logic [15:0] read_src;

  assign rw = rw_t'(control_word[5:4]);

  // Strobe rising edges; a write wins if both strobes somehow release together.
  assign write_event = ~wr_q & WR_n & ~CS_n;
  assign read_event  = ~rd_q & RD_n & ~CS_n & (A == ID) & ~write_event;

  assign ctrl_hit     = write_event & (A == CTRL_ADDR) & (D_in[7:6] == ID);
  assign readback_hit = write_event & (A == CTRL_ADDR) & (D_in[7:6] == READBACK_SC) & D_in[RB_BIT];
  assign data_hit     = write_event & (A == ID);

  assign ctrl_store   = ctrl_hit & (D_in[5:4] != RW_LATCH);
  assign latch_count  = (ctrl_hit & (D_in[5:4] == RW_LATCH)) | (readback_hit & ~D_in[5]);
  assign latch_status = readback_hit & ~D_in[4];

  // Write sequencer: control words, latches, CR assembly and read advance.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q           <= 1'b1;
      rd_q           <= 1'b1;
      control_word   <= 8'h00;
      initial_count  <= 16'h0000;
      CRL_enable     <= 1'b0;
      CRM_enable     <= 1'b0;
      count_written  <= 1'b0;
      write_pending  <= 1'b0;
      read_toggle    <= 1'b0;
      ol_latched     <= 1'b0;
      status_latched <= 1'b0;
      ol             <= 16'h0000;
      status         <= '0;
    end else begin
      wr_q          <= WR_n;
      rd_q          <= RD_n;
      CRL_enable    <= 1'b0;
      CRM_enable    <= 1'b0;
      count_written <= 1'b0;

      if (ctrl_store) begin
        // New mode: abandon any half-written count and all latched data.
        control_word   <= D_in;
        write_pending  <= 1'b0;
        read_toggle    <= 1'b0;
        ol_latched     <= 1'b0;
        status_latched <= 1'b0;
      end else begin
        if (latch_count && !ol_latched) begin
          ol         <= current_count;
          ol_latched <= 1'b1;
        end
        if (latch_status && !status_latched) begin
          status         <= {OUT, null_count, control_word[5:0]};
          status_latched <= 1'b1;
        end

        if (data_hit) begin
          case (rw)
            RW_LSB: begin
              initial_count <= {8'h00, D_in};
              CRL_enable    <= 1'b1;
              count_written <= 1'b1;
            end
            RW_MSB: begin
              initial_count <= {D_in, 8'h00};
              CRM_enable    <= 1'b1;
              count_written <= 1'b1;
            end
            RW_LSB_MSB: begin
              if (!write_pending) begin
                initial_count[7:0] <= D_in;
                CRL_enable         <= 1'b1;
                write_pending      <= 1'b1;
              end else begin
                initial_count[15:8] <= D_in;
                CRM_enable          <= 1'b1;
                count_written       <= 1'b1;
                write_pending       <= 1'b0;
              end
            end
            default: ;
          endcase
        end

        // Status byte is consumed before any count byte.
        if (read_event) begin
          if (status_latched) begin
            status_latched <= 1'b0;
          end else if (rw == RW_LSB_MSB) begin
            read_toggle <= ~read_toggle;
            if (read_toggle) ol_latched <= 1'b0;
          end else begin
            ol_latched <= 1'b0;
          end
        end
      end
    end
  end

  assign D_oe     = ~RESET & ~CS_n & ~RD_n & (A == ID);
  assign read_src = ol_latched ? ol : current_count;

  // Read mux: status, then latched count, then live count.
  always_comb begin
    D_out = 8'h00;
    if (D_oe) begin
      if (status_latched) begin
        D_out = status;
      end else begin
        case (rw)
          RW_MSB:     D_out = sel_byte(read_src, 1'b1);
          RW_LSB_MSB: D_out = sel_byte(read_src, read_toggle);
          default:    D_out = sel_byte(read_src, 1'b0);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_bus_interface.sv
// Self-checking bench for counter_bus_interface (COUNTER_ID = 0):
// directed scenarios followed by random bus traffic against a reference model.
module tb_counter_bus_interface;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CS_n, RD_n, WR_n;
  logic [1:0]  A;
  logic [7:0]  D_in;
  logic [15:0] current_count;
  logic        OUT, null_count;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  control_word;
  logic [15:0] initial_count;
  logic        CRL_enable, CRM_enable, count_written, write_pending;

  counter_bus_interface #(.COUNTER_ID(0)) dut (
    .CLK(CLK), .RESET(RESET), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .A(A), .D_in(D_in), .current_count(current_count), .OUT(OUT),
    .null_count(null_count), .D_out(D_out), .D_oe(D_oe),
    .control_word(control_word), .initial_count(initial_count),
    .CRL_enable(CRL_enable), .CRM_enable(CRM_enable),
    .count_written(count_written), .write_pending(write_pending)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the counter's programming state as the CPU sees it.
  logic [7:0]  m_cw;
  logic [15:0] m_cr;
  bit          m_half;      // LSB of a two-byte count already written
  bit          m_hi_next;   // next two-byte read returns the MSB
  bit          m_cnt_held;
  logic [15:0] m_cnt;
  bit          m_st_held;
  logic [7:0]  m_st;

  task automatic model_reset();
    m_cw = 8'h00; m_cr = 16'h0000; m_half = 0; m_hi_next = 0;
    m_cnt_held = 0; m_cnt = 16'h0000; m_st_held = 0; m_st = 8'h00;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [7:0] d,
                             output bit crl, output bit crm, output bit done);
    crl = 0; crm = 0; done = 0;
    if (a == 2'd3) begin
      if (d[7:6] == 2'd0) begin
        if (d[5:4] == 2'd0) begin
          if (!m_cnt_held) begin m_cnt = current_count; m_cnt_held = 1; end
        end else begin
          m_cw = d; m_half = 0; m_hi_next = 0; m_cnt_held = 0; m_st_held = 0;
        end
      end else if (d[7:6] == 2'd3 && d[1]) begin
        if (!d[5] && !m_cnt_held) begin m_cnt = current_count; m_cnt_held = 1; end
        if (!d[4] && !m_st_held) begin
          m_st = {OUT, null_count, m_cw[5:0]}; m_st_held = 1;
        end
      end
    end else if (a == 2'd0) begin
      case (m_cw[5:4])
        2'd1: begin m_cr = {8'h00, d}; crl = 1; done = 1; end
        2'd2: begin m_cr = {d, 8'h00}; crm = 1; done = 1; end
        2'd3: begin
          if (!m_half) begin m_cr = {m_cr[15:8], d}; crl = 1; m_half = 1; end
          else begin m_cr = {d, m_cr[7:0]}; crm = 1; done = 1; m_half = 0; end
        end
        default: ;
      endcase
    end
  endtask

  // Returns the byte the CPU should see and consumes it.
  task automatic model_read(output logic [7:0] b);
    logic [15:0] v;
    v = m_cnt_held ? m_cnt : current_count;
    if (m_st_held) begin
      b = m_st; m_st_held = 0;
    end else begin
      case (m_cw[5:4])
        2'd2: begin b = v[15:8]; m_cnt_held = 0; end
        2'd3: begin
          b = m_hi_next ? v[15:8] : v[7:0];
          if (m_hi_next) m_cnt_held = 0;
          m_hi_next = !m_hi_next;
        end
        default: begin b = v[7:0]; m_cnt_held = 0; end
      endcase
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d,
                           output bit crl, output bit crm, output bit done);
    @(negedge CLK); CS_n = 0; A = a; D_in = d; WR_n = 0;
    @(negedge CLK); WR_n = 1;
    @(posedge CLK); #1;
    crl = CRL_enable; crm = CRM_enable; done = count_written;
    @(negedge CLK); CS_n = 1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output bit oe);
    @(negedge CLK); CS_n = 0; A = a; RD_n = 0;
    @(posedge CLK); #1;
    d = D_out; oe = D_oe;
    @(negedge CLK); RD_n = 1;
    @(negedge CLK); CS_n = 1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                          output bit crl, output bit crm, output bit done);
    bit e_crl, e_crm, e_done;
    model_write(a, d, e_crl, e_crm, e_done);
    bus_write(a, d, crl, crm, done);
    check("crl_pulse", 32'(crl), 32'(e_crl));
    check("crm_pulse", 32'(crm), 32'(e_crm));
    check("count_written", 32'(done), 32'(e_done));
    check("initial_count", 32'(initial_count), 32'(m_cr));
    check("control_word", 32'(control_word), 32'(m_cw));
    check("write_pending", 32'(write_pending), 32'(m_half));
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] d);
    logic [7:0] e;
    bit oe;
    if (a == 2'd0) model_read(e);
    else e = 8'h00;
    bus_read(a, d, oe);
    check("d_oe", 32'(oe), 32'(a == 2'd0));
    check("d_out", 32'(d), 32'(e));
  endtask

  initial begin
    bit crl, crm, done;
    logic [7:0] rd;

    RESET = 1; CS_n = 1; RD_n = 1; WR_n = 1; A = 2'd0; D_in = 8'h00;
    current_count = 16'h0000; OUT = 0; null_count = 0;
    model_reset();
    #12;
    check("rst_cw", 32'(control_word), 32'h0);
    check("rst_cr", 32'(initial_count), 32'h0);
    check("rst_pulses", 32'({CRL_enable, CRM_enable, count_written, write_pending}), 32'h0);
    check("rst_oe", 32'({D_oe, D_out}), 32'h0);
    @(negedge CLK); RESET = 0;

    // Two-byte count write.
    do_write(2'd3, 8'h30, crl, crm, done);
    do_write(2'd0, 8'h34, crl, crm, done);
    check("t1_lsb_crl", 32'(crl), 32'h1);
    check("t1_lsb_pending", 32'(write_pending), 32'h1);
    do_write(2'd0, 8'h12, crl, crm, done);
    check("t1_msb_done", 32'({crm, done}), 32'h3);
    check("t1_cr", 32'(initial_count), 32'h1234);

    // LSB-only count write.
    do_write(2'd3, 8'h10, crl, crm, done);
    do_write(2'd0, 8'hAB, crl, crm, done);
    check("t2_pulses", 32'({crl, crm, done}), 32'h5);
    check("t2_cr", 32'(initial_count), 32'h00AB);

    // Counter latch holds the first value; a second latch is ignored.
    do_write(2'd3, 8'h30, crl, crm, done);
    current_count = 16'h5678;
    do_write(2'd3, 8'h00, crl, crm, done);
    current_count = 16'h1111;
    do_write(2'd3, 8'h00, crl, crm, done);
    do_read(2'd0, rd); check("t3_lsb", 32'(rd), 32'h78);
    do_read(2'd0, rd); check("t3_msb", 32'(rd), 32'h56);
    do_read(2'd0, rd); check("t3_live", 32'(rd), 32'h11);
    do_read(2'd0, rd);

    // Read-back of count and status.
    do_write(2'd3, 8'h36, crl, crm, done);
    OUT = 1; null_count = 0; current_count = 16'hBEEF;
    do_write(2'd3, 8'hC2, crl, crm, done);
    current_count = 16'h4242;
    do_read(2'd0, rd); check("t4_status", 32'(rd), 32'hB6);
    do_read(2'd0, rd); check("t4_lsb", 32'(rd), 32'hEF);
    do_read(2'd0, rd); check("t4_msb", 32'(rd), 32'hBE);
    do_read(2'd1, rd); check("t4_other_addr", 32'(rd), 32'h00);

    // A control write abandons a half-written count.
    do_write(2'd3, 8'h30, crl, crm, done);
    do_write(2'd0, 8'h01, crl, crm, done);
    do_write(2'd3, 8'h30, crl, crm, done);
    check("t5_pending", 32'({write_pending, done}), 32'h0);
    do_write(2'd0, 8'h02, crl, crm, done);
    do_write(2'd0, 8'h00, crl, crm, done);
    check("t5_cr", 32'(initial_count), 32'h0002);

    // Asynchronous reset between LSB and MSB writes.
    do_write(2'd0, 8'h55, crl, crm, done);
    @(negedge CLK); #2; RESET = 1; #1;
    check("t6_cw", 32'(control_word), 32'h0);
    check("t6_cr", 32'(initial_count), 32'h0);
    check("t6_pending", 32'(write_pending), 32'h0);
    model_reset();
    @(negedge CLK); RESET = 0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      logic [7:0] d;
      current_count = 16'($urandom);
      OUT = 1'($urandom);
      null_count = 1'($urandom);
      op = $urandom_range(0, 11);
      case (op)
        0, 1: begin
          d = {2'b00, 2'($urandom_range(1, 3)), 4'($urandom)};
          do_write(2'd3, d, crl, crm, done);
        end
        2: do_write(2'd3, {4'b0000, 4'($urandom)}, crl, crm, done);
        3: do_write(2'd3, {2'b11, 6'($urandom)}, crl, crm, done);
        4: do_write(2'd3, {2'($urandom_range(1, 2)), 6'($urandom)}, crl, crm, done);
        5, 6, 7: do_write(2'd0, 8'($urandom), crl, crm, done);
        8: do_write(2'($urandom_range(1, 2)), 8'($urandom), crl, crm, done);
        default: do_read((op == 11) ? 2'($urandom_range(0, 2)) : 2'd0, rd);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
